// File: rtl/uart_responder_pkg.sv
// Shared memory-op encodings, UART frame constants and op-class decode helpers
// used by the UART responder and its receive deserialiser.
package uart_responder_pkg;

    localparam logic [3:0] MEM_NOP = 4'd0;
    localparam logic [3:0] MEM_LB  = 4'd1;
    localparam logic [3:0] MEM_LBU = 4'd2;
    localparam logic [3:0] MEM_LH  = 4'd3;
    localparam logic [3:0] MEM_LHU = 4'd4;
    localparam logic [3:0] MEM_LW  = 4'd5;
    localparam logic [3:0] MEM_SB  = 4'd6;
    localparam logic [3:0] MEM_SH  = 4'd7;
    localparam logic [3:0] MEM_SW  = 4'd8;

    localparam int UART_FRAME_BITS = 10;
    localparam int DATA_BITS       = 8;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_t;

    function automatic logic is_store_op(input logic [3:0] op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    function automatic logic is_load_op(input logic [3:0] op);
        return (op == MEM_LB) || (op == MEM_LBU) || (op == MEM_LH) ||
               (op == MEM_LHU) || (op == MEM_LW);
    endfunction

endpackage

// File: rtl/uart_responder_if.sv
// CPU-side bus of the UART window: routed op and store data in, load data and
// the two status bits out.
interface uart_responder_if;
    logic [3:0]  uartOp_i;
    logic [31:0] uart_storeData_i;
    logic [31:0] uart_load_data_o;
    logic        dataReady;
    logic        writeReady;

    modport master (
        output uartOp_i, uart_storeData_i,
        input  uart_load_data_o, dataReady, writeReady
    );

    modport slave (
        input  uartOp_i, uart_storeData_i,
        output uart_load_data_o, dataReady, writeReady
    );
endinterface

// File: rtl/uart_responder_rx_deser.sv
// 8N1 receiver: 2-flop rxd synchroniser plus mid-bit sampling FSM; emits a
// one-cycle byte_valid with the byte when a frame ends in a valid stop bit.
module uart_rx_deser
    import uart_responder_pkg::*;
#(
    parameter int CLKS_PER_BIT = 96
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic       byte_valid,
    output logic [7:0] rx_byte
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    uart_state_t      state_reg, state_next;
    logic [1:0]       sync_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]       bit_reg;
    logic [7:0]       shift_reg;
    logic             byte_valid_reg;
    logic [7:0]       byte_reg;
    logic             rx_s, bit_end, half_end, data_strobe, stop_strobe;

    assign rx_s     = sync_reg[1];
    assign bit_end  = (cnt_reg == BIT_LAST);
    assign half_end = (cnt_reg == HALF_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg       <= 2'b11;
            state_reg      <= UART_IDLE;
            cnt_reg        <= '0;
            bit_reg        <= 3'd0;
            shift_reg      <= 8'd0;
            byte_valid_reg <= 1'b0;
            byte_reg       <= 8'd0;
        end else begin
            sync_reg  <= {sync_reg[0], rxd};
            state_reg <= state_next;
            // Counter restarts on every state change so START measures a half bit
            // and DATA/STOP then land in the middle of each following bit.
            cnt_reg <= (state_reg == UART_IDLE || state_next != state_reg || bit_end)
                       ? '0 : cnt_reg + 1'b1;
            if (data_strobe) begin
                shift_reg <= {rx_s, shift_reg[7:1]};
                bit_reg   <= bit_reg + 3'd1;
            end
            byte_valid_reg <= stop_strobe && rx_s;
            if (stop_strobe && rx_s) byte_reg <= shift_reg;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            UART_IDLE:  if (!rx_s) state_next = UART_START;
            UART_START: if (half_end) state_next = rx_s ? UART_IDLE : UART_DATA;
            UART_DATA:  if (bit_end && bit_reg == 3'd7) state_next = UART_STOP;
            UART_STOP:  if (bit_end) state_next = UART_IDLE;
            default:    state_next = UART_IDLE;
        endcase
    end

    always_comb begin
        data_strobe = (state_reg == UART_DATA) && bit_end;
        stop_strobe = (state_reg == UART_STOP) && bit_end;
    end

    assign byte_valid = byte_valid_reg;
    assign rx_byte    = byte_reg;
endmodule

// File: rtl/uart_responder.sv
// Memory-mapped UART responder: 8N1 transmitter, receive path and status bits.
// Optional build macro UART_RX_FIFO_EN swaps the RX holding register for a 4-deep FIFO.
module uart_responder
    import uart_responder_pkg::*;
#(
    parameter int CLKS_PER_BIT = 96
) (
    input  logic             clk,
    input  logic             rst,
    uart_responder_if.slave  bus,
    input  logic             rxd,
    output logic             txd
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    uart_state_t      tx_state_reg, tx_state_next;
    logic [CNT_W-1:0] tx_cnt_reg;
    logic [2:0]       tx_bit_reg;
    logic [7:0]       tx_shift_reg;
    logic             tx_bit_end, store_accept, load_op;
    logic             rx_valid;
    logic [7:0]       rx_byte;
    logic [23:0]      unused_store_bits;

    assign unused_store_bits = bus.uart_storeData_i[31:8];
    assign tx_bit_end   = (tx_cnt_reg == BIT_LAST);
    assign store_accept = is_store_op(bus.uartOp_i) && (tx_state_reg == UART_IDLE);
    assign load_op      = is_load_op(bus.uartOp_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_reg <= UART_IDLE;
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= 3'd0;
            tx_shift_reg <= 8'd0;
        end else begin
            tx_state_reg <= tx_state_next;
            tx_cnt_reg   <= (tx_state_reg == UART_IDLE || tx_bit_end) ? '0 : tx_cnt_reg + 1'b1;
            if (tx_state_reg == UART_DATA && tx_bit_end) tx_bit_reg <= tx_bit_reg + 3'd1;
            if (store_accept) tx_shift_reg <= bus.uart_storeData_i[7:0];
        end
    end

    always_comb begin
        tx_state_next = tx_state_reg;
        case (tx_state_reg)
            UART_IDLE:  if (store_accept) tx_state_next = UART_START;
            UART_START: if (tx_bit_end) tx_state_next = UART_DATA;
            UART_DATA:  if (tx_bit_end && tx_bit_reg == 3'd7) tx_state_next = UART_STOP;
            UART_STOP:  if (tx_bit_end) tx_state_next = UART_IDLE;
            default:    tx_state_next = UART_IDLE;
        endcase
    end

    always_comb begin
        txd            = 1'b1;
        bus.writeReady = 1'b0;
        case (tx_state_reg)
            UART_IDLE:  bus.writeReady = 1'b1;
            UART_START: txd = 1'b0;
            UART_DATA:  txd = tx_shift_reg[tx_bit_reg];
            default:    txd = 1'b1;
        endcase
    end

    uart_rx_deser #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_deser (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rxd),
        .byte_valid (rx_valid),
        .rx_byte    (rx_byte)
    );

`ifndef UART_RX_FIFO_EN
    logic [7:0] rx_hold_reg;
    logic       rx_ready_reg;

    // A commit in the same cycle as a load wins: the new byte stays pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_hold_reg  <= 8'd0;
            rx_ready_reg <= 1'b0;
        end else if (rx_valid) begin
            rx_hold_reg  <= rx_byte;
            rx_ready_reg <= 1'b1;
        end else if (load_op) begin
            rx_ready_reg <= 1'b0;
        end
    end

    assign bus.dataReady        = rx_ready_reg;
    assign bus.uart_load_data_o = {24'b0, rx_hold_reg};
`else
    logic [1:0] wptr_reg, rptr_reg;
    logic [2:0] count_reg;
    logic       push, pop;
    logic [7:0] fifo_view [4];

    assign pop  = load_op && (count_reg != 3'd0);
    assign push = rx_valid && ((count_reg != 3'd4) || pop);

    for (genvar gi = 0; gi < 4; gi++) begin : g_entry
        logic [7:0] entry_reg;
        always_ff @(posedge clk) begin
            if (rst) entry_reg <= 8'd0;
            else if (push && wptr_reg == 2'(gi)) entry_reg <= rx_byte;
        end
        assign fifo_view[gi] = entry_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_reg  <= 2'd0;
            rptr_reg  <= 2'd0;
            count_reg <= 3'd0;
        end else begin
            if (push) wptr_reg <= wptr_reg + 2'd1;
            if (pop)  rptr_reg <= rptr_reg + 2'd1;
            count_reg <= count_reg + 3'(push) - 3'(pop);
        end
    end

    assign bus.dataReady        = (count_reg != 3'd0);
    assign bus.uart_load_data_o = {24'b0, fifo_view[rptr_reg]};
`endif
endmodule

// File: tb/tb_uart_responder.sv
// Randomised self-checking bench for uart_responder: serial frames are compared
// against bit-level expectations and RX status against a queue/register model.
module tb_uart_responder;
    import uart_responder_pkg::*;

    localparam int CPB = 16;
    localparam int FRAME = UART_FRAME_BITS * CPB;

    logic clk = 1'b0;
    logic rst, rxd, txd;
    int   err_cnt = 0;
    int   chk_cnt = 0;
    int   commit_at = 155;
    int   rise;

    always #5 clk = ~clk;

    uart_responder_if bus();

    uart_responder #(.CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .rxd (rxd),
        .txd (txd)
    );

`ifdef UART_RX_FIFO_EN
    logic [7:0] exp_q[$];
`else
    logic [7:0] exp_byte  = 8'd0;
    logic       exp_ready = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bit k of a serial frame: start 0, data LSB first, then the stop level.
    function automatic logic frame_bit(input logic [7:0] b, input int k, input logic stop);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        return stop;
    endfunction

    task automatic model_reset();
`ifdef UART_RX_FIFO_EN
        exp_q.delete();
`else
        exp_byte  = 8'd0;
        exp_ready = 1'b0;
`endif
    endtask

    task automatic model_step(input bit commit, input logic [7:0] b, input bit load);
`ifdef UART_RX_FIFO_EN
        bit full = (exp_q.size() == 4);
        bit pop  = load && (exp_q.size() > 0);
        if (pop) void'(exp_q.pop_front());
        if (commit && (!full || pop)) exp_q.push_back(b);
`else
        if (commit) begin
            exp_byte  = b;
            exp_ready = 1'b1;
        end else if (load) begin
            exp_ready = 1'b0;
        end
`endif
    endtask

    task automatic check_rx(input string tag);
`ifdef UART_RX_FIFO_EN
        check({tag, "_rdy"}, {31'b0, bus.dataReady}, {31'b0, exp_q.size() != 0});
        if (exp_q.size() != 0) check({tag, "_data"}, bus.uart_load_data_o, {24'b0, exp_q[0]});
`else
        check({tag, "_rdy"}, {31'b0, bus.dataReady}, {31'b0, exp_ready});
        check({tag, "_data"}, bus.uart_load_data_o, {24'b0, exp_byte});
`endif
    endtask

    task automatic tx_frame(input logic [7:0] b, input logic [3:0] op, input bit hold, input bit inject);
        logic [31:0] d;
        d = $urandom;
        d[7:0] = b;
        @(negedge clk);
        check("tx_idle_wr", {31'b0, bus.writeReady}, 32'd1);
        bus.uartOp_i = op;
        bus.uart_storeData_i = d;
        for (int j = 0; j <= FRAME; j++) begin
            @(negedge clk);
            if (j == 0) begin
                check("tx_lat_txd", {31'b0, txd}, 32'd0);
                check("tx_busy_wr", {31'b0, bus.writeReady}, 32'd0);
                if (!hold) bus.uartOp_i = MEM_NOP;
            end
            if (j < FRAME && (j % CPB) == CPB / 2)
                check($sformatf("tx_bit%0d", j / CPB), {31'b0, txd},
                      {31'b0, frame_bit(b, j / CPB, 1'b1)});
            if (j == FRAME - 1) check("tx_wr_last", {31'b0, bus.writeReady}, 32'd0);
            if (j == FRAME) begin
                check("tx_wr_done", {31'b0, bus.writeReady}, 32'd1);
                check("tx_done_txd", {31'b0, txd}, 32'd1);
            end
            if (inject && j == 40) begin
                bus.uartOp_i = MEM_SW;
                bus.uart_storeData_i = 32'h0000003C;
            end
            if (inject && j == 41) bus.uartOp_i = MEM_NOP;
        end
        if (hold) begin
            @(negedge clk);
            check("tx_resend_txd", {31'b0, txd}, 32'd0);
            check("tx_resend_wr", {31'b0, bus.writeReady}, 32'd0);
            bus.uartOp_i = MEM_NOP;
            repeat (FRAME) @(negedge clk);
        end else begin
            repeat (20) @(negedge clk);
            check("tx_quiet_txd", {31'b0, txd}, 32'd1);
        end
        check("tx_after_wr", {31'b0, bus.writeReady}, 32'd1);
        $display("tx byte 0x%02h hold=%0d inject=%0d", b, hold, inject);
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop, input int load_at, output int rise_o);
        logic was;
        rise_o = -1;
        was = bus.dataReady;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (rise_o < 0 && bus.dataReady && !was) rise_o = i;
            was = bus.dataReady;
            rxd = frame_bit(b, i / CPB, stop);
            bus.uartOp_i = (i == load_at) ? MEM_LW : MEM_NOP;
        end
        @(negedge clk);
        if (rise_o < 0 && bus.dataReady && !was) rise_o = FRAME;
        rxd = 1'b1;
        bus.uartOp_i = MEM_NOP;
        repeat (20) @(negedge clk);
        model_step(stop, b, load_at >= 0);
        check_rx($sformatf("rx_%02h", b));
        $display("rx byte 0x%02h stop=%0d load_at=%0d", b, stop, load_at);
    endtask

    task automatic do_load(input logic [3:0] op);
        @(negedge clk);
        bus.uartOp_i = op;
        @(negedge clk);
        bus.uartOp_i = MEM_NOP;
        model_step(1'b0, 8'd0, 1'b1);
        check_rx("load");
        $display("load op %0d", op);
    endtask

    task automatic rx_glitch();
        @(negedge clk);
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (CPB * 2) @(negedge clk);
        check_rx("glitch");
        $display("rx glitch");
    endtask

    initial begin
        logic [3:0] loads [5];
        loads = '{MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW};

        rst = 1'b1;
        rxd = 1'b1;
        bus.uartOp_i = MEM_NOP;
        bus.uart_storeData_i = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_txd", {31'b0, txd}, 32'd1);
        check("rst_wr", {31'b0, bus.writeReady}, 32'd1);
        check("rst_rdy", {31'b0, bus.dataReady}, 32'd0);
        check("rst_data", bus.uart_load_data_o, 32'd0);

        tx_frame(8'hA5, MEM_SB, 1'b0, 1'b1);
        tx_frame(8'hC3, MEM_SH, 1'b1, 1'b0);

        rx_frame(8'h5A, 1'b1, -1, rise);
        check("rx_latency_ok", {31'b0, (rise >= 0 && rise <= FRAME + 2)}, 32'd1);
        if (rise > 0) commit_at = rise - 1;
        do_load(MEM_LW);
        do_load(MEM_LW);

        rx_glitch();
        rx_frame(8'h11, 1'b0, -1, rise);

        rx_frame(8'h01, 1'b1, -1, rise);
        rx_frame(8'h02, 1'b1, -1, rise);
        rx_frame(8'h03, 1'b1, commit_at, rise);
        repeat (5) do_load(MEM_LW);

        for (int k = 0; k < 5; k++) rx_frame(8'(8'h10 + k), 1'b1, -1, rise);
        repeat (5) do_load(loads[$urandom_range(0, 4)]);

        for (int n = 0; n < 14; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 5)      rx_frame(8'($urandom), ($urandom_range(0, 4) != 0), -1, rise);
            else if (r < 7) do_load(loads[$urandom_range(0, 4)]);
            else if (r < 8) rx_glitch();
            else            tx_frame(8'($urandom), MEM_SB, 1'($urandom_range(0, 1)), 1'b0);
        end

        // Reset in the middle of a transmitted frame.
        @(negedge clk);
        bus.uartOp_i = MEM_SW;
        bus.uart_storeData_i = 32'h00000000;
        @(negedge clk);
        bus.uartOp_i = MEM_NOP;
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("midrst_txd", {31'b0, txd}, 32'd1);
        check("midrst_wr", {31'b0, bus.writeReady}, 32'd1);
        check("midrst_rdy", {31'b0, bus.dataReady}, 32'd0);
        check("midrst_data", bus.uart_load_data_o, 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
